dro_bank_scheduler: RTL and testbench

- Sequences write (set) and destructive-read (reset) requests onto a bank of N_CELLS basic DRO cells.
- Both DRO inputs are dual-edge triggered, so every set or reset event is a toggle of the corresponding drive line.
- Tracks each cell's stored state and enforces a minimum gap between successive edges on the same cell, covering the cell's set/reset hold windows.
- Arbitrates between the write and read ports, waits for the cell's out toggle on a read, and returns the read bit.

---
 rtl/dro_bank_scheduler.sv | 170 +++++++++++++++++
 tb/tb_dro_bank_scheduler.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dro_bank_scheduler.sv
// Write/destructive-read scheduler for a bank of dual-edge DRO cells.
// Set and reset are toggle encoded. A per-cell gap counter spaces successive edges on one cell.
// The write and read ports share a single grant with alternating priority.
// A read waits for the synchronized out toggle and returns one response bit.
module dro_bank_scheduler #(
    parameter int unsigned N_CELLS    = 4,
    parameter int unsigned IDX_W      = 2,
    parameter int unsigned GAP_CYCLES = 3,
    parameter int unsigned RD_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    input  logic [IDX_W-1:0]   wr_idx,
    output logic               wr_ready,
    input  logic               rd_valid,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_ready,
    output logic               rd_resp_valid,
    output logic               rd_resp_data,
    output logic [N_CELLS-1:0] set_o,
    output logic [N_CELLS-1:0] reset_o,
    input  logic [N_CELLS-1:0] out_i,
    output logic [N_CELLS-1:0] cell_full,
    output logic               err_timeout
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [3:0] GapLoad = 4'(GAP_CYCLES);
    localparam logic [7:0] ToLast  = 8'(RD_TIMEOUT - 1);

    logic [1:0]               state_q, state_d;
    logic [N_CELLS-1:0][3:0]  gap_q, gap_d;
    logic [N_CELLS-1:0]       full_q, full_d;
    logic [N_CELLS-1:0]       set_q, set_d;
    logic [N_CELLS-1:0]       reset_q, reset_d;
    logic [N_CELLS-1:0]       sync1_q, sync2_q;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [7:0]               to_cnt_q, to_cnt_d;
    logic                     data_q, data_d;
    logic                     err_q, err_d;
    logic                     prio_rd_q, prio_rd_d;

    logic wr_elig, rd_elig, contend, wr_fire, rd_fire, out_tog;
    logic [N_CELLS-1:0] tog_vec;

    // Port readiness and arbitration between the two request ports
    always_comb begin
        wr_elig  = (gap_q[wr_idx] == 4'd0);
        rd_elig  = (gap_q[rd_idx] == 4'd0);
        contend  = wr_valid && wr_elig && rd_valid && rd_elig;
        // Readies are forced low while rst is held so every output reads 0
        wr_ready = !rst && (state_q == StIdle) && wr_elig && !(rd_valid && rd_elig && prio_rd_q);
        rd_ready = !rst && (state_q == StIdle) && rd_elig && !(wr_valid && wr_elig && !prio_rd_q);
        wr_fire  = wr_valid && wr_ready;
        rd_fire  = rd_valid && rd_ready;
        // Flag the out change of the selected cell as it moves into the second sync stage
        tog_vec  = sync1_q ^ sync2_q;
        out_tog  = tog_vec[idx_q];
    end

    // Next-state: FSM, cell state model, edge issue, gap counters
    always_comb begin
        state_d   = state_q;
        full_d    = full_q;
        set_d     = set_q;
        reset_d   = reset_q;
        idx_d     = idx_q;
        to_cnt_d  = to_cnt_q;
        data_d    = data_q;
        err_d     = err_q;
        prio_rd_d = prio_rd_q;
        gap_d     = gap_q;
        for (int i = 0; i < N_CELLS; i++) begin
            if (gap_q[i] != 4'd0) begin
                gap_d[i] = gap_q[i] - 4'd1;
            end
        end
        case (state_q)
            StIdle: begin
                if (contend) begin
                    prio_rd_d = !prio_rd_q;
                end
                if (wr_fire) begin
                    // Writing a full cell is a no-op
                    if (!full_q[wr_idx]) begin
                        set_d[wr_idx]  = !set_q[wr_idx];
                        full_d[wr_idx] = 1'b1;
                        gap_d[wr_idx]  = GapLoad;
                    end
                end else if (rd_fire) begin
                    idx_d = rd_idx;
                    if (full_q[rd_idx]) begin
                        reset_d[rd_idx] = !reset_q[rd_idx];
                        full_d[rd_idx]  = 1'b0;
                        gap_d[rd_idx]   = GapLoad;
                        to_cnt_d        = 8'd0;
                        state_d         = StWait;
                    end else begin
                        data_d  = 1'b0;
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (out_tog) begin
                    data_d  = 1'b1;
                    state_d = StResp;
                end else if (to_cnt_q == ToLast) begin
                    data_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers, out_i synchronizers included
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            gap_q     <= '0;
            full_q    <= '0;
            set_q     <= '0;
            reset_q   <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            idx_q     <= '0;
            to_cnt_q  <= '0;
            data_q    <= 1'b0;
            err_q     <= 1'b0;
            prio_rd_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            full_q    <= full_d;
            set_q     <= set_d;
            reset_q   <= reset_d;
            sync1_q   <= out_i;
            sync2_q   <= sync1_q;
            idx_q     <= idx_d;
            to_cnt_q  <= to_cnt_d;
            data_q    <= data_d;
            err_q     <= err_d;
            prio_rd_q <= prio_rd_d;
        end
    end

    // Registered outputs
    always_comb begin
        rd_resp_valid = (state_q == StResp);
        rd_resp_data  = (state_q == StResp) && data_q;
        set_o         = set_q;
        reset_o       = reset_q;
        cell_full     = full_q;
        err_timeout   = err_q;
    end

endmodule

// File: tb/tb_dro_bank_scheduler.sv
// Self-checking bench for dro_bank_scheduler with a DRO out model and a response scoreboard.
module tb_dro_bank_scheduler;

    localparam int RdTimeout = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [1:0] wr_idx = 2'd0;
    logic       wr_ready;
    logic       rd_valid = 1'b0;
    logic [1:0] rd_idx = 2'd0;
    logic       rd_ready;
    logic       rd_resp_valid;
    logic       rd_resp_data;
    logic [3:0] set_o;
    logic [3:0] reset_o;
    logic [3:0] out_sig = 4'd0;
    logic [3:0] cell_full;
    logic       err_timeout;

    dro_bank_scheduler #(
        .N_CELLS(4),
        .IDX_W(2),
        .GAP_CYCLES(3),
        .RD_TIMEOUT(RdTimeout)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_valid(wr_valid),
        .wr_idx(wr_idx),
        .wr_ready(wr_ready),
        .rd_valid(rd_valid),
        .rd_idx(rd_idx),
        .rd_ready(rd_ready),
        .rd_resp_valid(rd_resp_valid),
        .rd_resp_data(rd_resp_data),
        .set_o(set_o),
        .reset_o(reset_o),
        .out_i(out_sig),
        .cell_full(cell_full),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic data;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [3:0] model_full = 4'd0;
    logic [3:0] prev_set = 4'd0;
    logic [3:0] prev_reset = 4'd0;
    logic [3:0] pending = 4'd0;
    logic       dro_en = 1'b1;
    logic       last_wf, last_rf;
    int         acc_wr_cyc, acc_rd_cyc;
    int         set_edges = 0;
    int         rst_edges = 0;
    int         set_edge_cyc[4];
    int         rst_edge_cyc[4];

    // One clock cycle: record handshakes, advance, run DRO model, score responses
    task automatic step();
        exp_t e;
        #2;
        last_wf = wr_valid && wr_ready;
        last_rf = rd_valid && rd_ready;
        if (last_wf) begin
            acc_wr_cyc = cyc;
            model_full[wr_idx] = 1'b1;
        end
        if (last_rf) begin
            acc_rd_cyc = cyc;
            if (model_full[rd_idx]) begin
                model_full[rd_idx] = 1'b0;
                e.cyc  = dro_en ? cyc + 4 : cyc + 1 + RdTimeout;
                e.data = dro_en;
            end else begin
                e.cyc  = cyc + 1;
                e.data = 1'b0;
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (pending[i]) begin
                out_sig[i] = ~out_sig[i];
                pending[i] = 1'b0;
            end
            if (reset_o[i] !== prev_reset[i]) begin
                rst_edges++;
                rst_edge_cyc[i] = cyc;
                if (dro_en) pending[i] = 1'b1;
            end
            if (set_o[i] !== prev_set[i]) begin
                set_edges++;
                set_edge_cyc[i] = cyc;
            end
        end
        prev_reset = reset_o;
        prev_set   = set_o;
        checks++;
        if (cell_full !== model_full) begin
            failures++;
            $display("FAIL cell_full_track cyc=%0d got=%b want=%b", cyc, cell_full, model_full);
        end
        if (rd_resp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected cyc=%0d got data=%b want no response", cyc,
                         rd_resp_data);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.data !== rd_resp_data) begin
                    failures++;
                    $display("FAIL resp cyc got=%0d want=%0d data got=%b want=%b", cyc, e.cyc,
                             rd_resp_data, e.data);
                end
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && exp_q.size() > 0; k++) step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL resp_missing got=none want=%0d responses", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic reset_assert();
        rst        = 1'b1;
        wr_valid   = 1'b0;
        rd_valid   = 1'b0;
        out_sig    = 4'd0;
        model_full = 4'd0;
        pending    = 4'd0;
        prev_set   = 4'd0;
        prev_reset = 4'd0;
        exp_q.delete();
        #1;
    endtask

    task automatic reset_release();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_assert();
        checks += 4;
        if ({set_o, reset_o, cell_full} !== 12'd0) begin
            failures++;
            $display("FAIL reset_drive got=%h want=0", {set_o, reset_o, cell_full});
        end
        if ({rd_resp_valid, rd_resp_data, err_timeout} !== 3'd0) begin
            failures++;
            $display("FAIL reset_resp got=%b want=000", {rd_resp_valid, rd_resp_data, err_timeout});
        end
        if ({wr_ready, rd_ready} !== 2'd0) begin
            failures++;
            $display("FAIL reset_ready got=%b want=00", {wr_ready, rd_ready});
        end
        reset_release();
        #1;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_wr_ready got=%b want=1", wr_ready);
        end
    endtask

    task automatic test_write();
        int n, se;
        wr_valid = 1'b1;
        wr_idx   = 2'd2;
        step();
        wr_valid = 1'b0;
        n = acc_wr_cyc;
        checks += 3;
        if (last_wf !== 1'b1) begin
            failures++;
            $display("FAIL wr_accept got=%b want=1", last_wf);
        end
        if (set_o !== 4'b0100 || cell_full !== 4'b0100) begin
            failures++;
            $display("FAIL wr_set got set=%b full=%b want 0100/0100", set_o, cell_full);
        end
        if (set_edge_cyc[2] != n + 1) begin
            failures++;
            $display("FAIL wr_edge_time got=%0d want=%0d", set_edge_cyc[2], n + 1);
        end
        repeat (3) step();
        se       = set_edges;
        wr_valid = 1'b1;
        wr_idx   = 2'd2;
        step();
        wr_valid = 1'b0;
        step();
        checks += 2;
        if (last_wf !== 1'b0 && 1'b0) failures++;
        if (set_edges != se) begin
            failures++;
            $display("FAIL wr_idempotent_edges got=%0d want=%0d", set_edges, se);
        end
        if (set_o !== 4'b0100 || cell_full !== 4'b0100) begin
            failures++;
            $display("FAIL wr_idempotent_state got set=%b full=%b want 0100/0100", set_o, cell_full);
        end
    endtask

    task automatic test_read_full();
        int n;
        dro_en   = 1'b1;
        rd_valid = 1'b1;
        rd_idx   = 2'd2;
        step();
        rd_valid = 1'b0;
        n = acc_rd_cyc;
        checks += 2;
        if (last_rf !== 1'b1) begin
            failures++;
            $display("FAIL rd_accept got=%b want=1", last_rf);
        end
        if (reset_o !== 4'b0100 || rst_edge_cyc[2] != n + 1) begin
            failures++;
            $display("FAIL rd_reset_edge got=%b@%0d want=0100@%0d", reset_o, rst_edge_cyc[2], n + 1);
        end
        drain();
        checks++;
        if (cell_full[2] !== 1'b0 || err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL rd_after got full2=%b err=%b want 0/0", cell_full[2], err_timeout);
        end
    endtask

    task automatic test_read_empty();
        int rs;
        rs       = rst_edges;
        rd_valid = 1'b1;
        rd_idx   = 2'd1;
        step();
        rd_valid = 1'b0;
        drain();
        checks++;
        if (rst_edges != rs || reset_o !== 4'b0100) begin
            failures++;
            $display("FAIL rd_empty_no_edge got=%0d/%b want=%0d/0100", rst_edges, reset_o, rs);
        end
    endtask

    task automatic test_gap();
        int   zeros;
        logic fired;
        zeros    = 0;
        fired    = 1'b0;
        wr_valid = 1'b1;
        wr_idx   = 2'd0;
        step();
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_idx   = 2'd0;
        for (int k = 0; k < 10 && !fired; k++) begin
            step();
            if (last_rf) fired = 1'b1;
            else zeros++;
        end
        rd_valid = 1'b0;
        checks += 2;
        if (!fired || zeros != 3) begin
            failures++;
            $display("FAIL gap_ready_low got=%0d fired=%b want=3 fired=1", zeros, fired);
        end
        if (rst_edge_cyc[0] - set_edge_cyc[0] < 4) begin
            failures++;
            $display("FAIL gap_edge_spacing got=%0d want>=4", rst_edge_cyc[0] - set_edge_cyc[0]);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [5:0] seq;
        int         grants;
        seq    = 6'd0;
        grants = 0;
        reset_assert();
        reset_release();
        wr_valid = 1'b1;
        wr_idx   = 2'd0;
        rd_valid = 1'b1;
        rd_idx   = 2'd3;
        for (int k = 0; k < 40 && grants < 6; k++) begin
            step();
            if (last_wf || last_rf) begin
                seq = {seq[4:0], last_rf};
                grants++;
                if (last_wf) wr_idx = wr_idx + 2'd1;
            end
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        checks++;
        if (grants != 6 || seq !== 6'b101010) begin
            failures++;
            $display("FAIL arb_order got=%b(%0d) want=101010(6)", seq, grants);
        end
        drain();
    endtask

    task automatic test_timeout();
        logic fired;
        int   n;
        fired    = 1'b0;
        dro_en   = 1'b0;
        rd_valid = 1'b1;
        rd_idx   = 2'd1;
        for (int k = 0; k < 10 && !fired; k++) begin
            step();
            fired = last_rf;
        end
        rd_valid = 1'b0;
        n = acc_rd_cyc;
        checks += 2;
        if (!fired || rst_edge_cyc[1] != n + 1) begin
            failures++;
            $display("FAIL to_accept got fired=%b edge=%0d want 1/%0d", fired, rst_edge_cyc[1], n + 1);
        end
        drain();
        if (err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL to_err got=%b want=1", err_timeout);
        end
        repeat (3) step();
        checks++;
        if (err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL to_err_sticky got=%b want=1", err_timeout);
        end
        // Abandon a read mid-WAIT_OUT with reset
        fired    = 1'b0;
        rd_valid = 1'b1;
        rd_idx   = 2'd0;
        for (int k = 0; k < 10 && !fired; k++) begin
            step();
            fired = last_rf;
        end
        rd_valid = 1'b0;
        repeat (3) step();
        reset_assert();
        checks += 2;
        if (!fired) begin
            failures++;
            $display("FAIL midrst_accept got=0 want=1");
        end
        if ({set_o, reset_o, cell_full, rd_resp_valid, rd_resp_data, err_timeout, wr_ready,
             rd_ready} !== 17'd0) begin
            failures++;
            $display("FAIL midrst_outputs got=%h want=0", {set_o, reset_o, cell_full,
                     rd_resp_valid, rd_resp_data, err_timeout, wr_ready, rd_ready});
        end
        reset_release();
        repeat (12) step();
        checks++;
        if (err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL midrst_err got=%b want=0", err_timeout);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_full();
        test_read_empty();
        test_gap();
        test_back_to_back();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
